thermal_tx_scheduler: RTL and testbench

THERMAL_TX_SCHEDULER -- requirements
Module: thermal_tx_scheduler

---
 rtl/thermal_tx_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_thermal_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_tx_scheduler.sv
// Thermal covert-channel transmit scheduler.
// Accepts one byte per frame and keys a ring-oscillator heater bank slot by
// slot: four preamble slots, eight data slots (LSB first) and one even-parity
// slot, followed by a heater-off guard interval that lets the die cool before
// the next frame. Each slot lasts BIT_CYCLES clocks; the guard lasts
// GUARD_CYCLES clocks. An abort cuts the frame short but still runs a full
// guard so the receiver always sees a clean cool-down.

module thermal_tx_scheduler #(
  parameter int unsigned BIT_CYCLES   = 33554432,
  parameter int unsigned GUARD_CYCLES = 16777216,
  parameter logic [3:0]  PREAMBLE     = 4'b1010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       abort,
  output logic       heat_en,
  output logic       slot_strobe,
  output logic [3:0] slot_idx,
  output logic       busy,
  output logic       done
);

  // Terminal counts for the slot and guard counters.
  localparam logic [31:0] BIT_LAST   = 32'(BIT_CYCLES - 32'd1);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 32'd1);

  // Slot numbers at which each transmitting phase hands over to the next.
  localparam logic [3:0] SLOT_PRE_END  = 4'd3;
  localparam logic [3:0] SLOT_DATA_END = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PARITY,
    ST_GUARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] slot_cnt;
  logic [31:0] guard_cnt;
  logic [3:0]  slot;
  logic [7:0]  data_q;
  logic        handshake;
  logic        active;
  logic        slot_last;
  logic        guard_last;
  logic [15:0] frame_bits;

  assign slot_idx = slot;

  // Next-state logic plus all combinational outputs derived from the current state.
  always_comb begin
    state_next  = state;
    handshake   = 1'b0;
    active      = 1'b0;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    slot_strobe = 1'b0;
    heat_en     = 1'b0;
    slot_last   = (slot_cnt == BIT_LAST);
    guard_last  = (guard_cnt == GUARD_LAST);

    // Bit k of frame_bits is the heater value for slot k; the preamble is
    // reversed so that its MSB lands in slot 0.
    frame_bits = {3'b000, ^data_q, data_q,
                  PREAMBLE[0], PREAMBLE[1], PREAMBLE[2], PREAMBLE[3]};

    case (state)
      ST_IDLE: begin
        tx_ready  = 1'b1;
        busy      = 1'b0;
        handshake = tx_valid;
        if (tx_valid) begin
          state_next = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        active = 1'b1;
        if (abort) begin
          state_next = ST_GUARD;
        end else if (slot_last && (slot == SLOT_PRE_END)) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        active = 1'b1;
        if (abort) begin
          state_next = ST_GUARD;
        end else if (slot_last && (slot == SLOT_DATA_END)) begin
          state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        active = 1'b1;
        if (abort || slot_last) begin
          state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_last) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (active) begin
      slot_strobe = (slot_cnt == 32'd0);
      heat_en     = frame_bits[slot];
    end
  end

  // State register; reset always lands in IDLE without passing through GUARD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Per-slot cycle counter and slot index; the index freezes during GUARD and clears on return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= 32'd0;
      slot     <= 4'd0;
    end else if (active) begin
      if (state_next == ST_GUARD) begin
        slot_cnt <= 32'd0;
      end else if (slot_last) begin
        slot_cnt <= 32'd0;
        slot     <= slot + 4'd1;
      end else begin
        slot_cnt <= slot_cnt + 32'd1;
      end
    end else begin
      slot_cnt <= 32'd0;
      if (state_next == ST_IDLE) begin
        slot <= 4'd0;
      end
    end
  end

  // Guard interval counter; restarts from zero on every entry into GUARD, including after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_cnt <= 32'd0;
    end else if ((state == ST_GUARD) && (state_next == ST_GUARD)) begin
      guard_cnt <= guard_cnt + 32'd1;
    end else begin
      guard_cnt <= 32'd0;
    end
  end

  // Payload byte captured on the handshake and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'd0;
    end else if (handshake) begin
      data_q <= tx_data;
    end
  end

  // One-cycle completion pulse on the first IDLE cycle after the guard expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_GUARD) && guard_last;
    end
  end

endmodule

// File: tb/tb_thermal_tx_scheduler.sv
// Self-checking bench for thermal_tx_scheduler with a short slot and guard.
// A reference model derives every expected output from the time elapsed
// since the handshake (or since guard entry) using plain arithmetic.

module tb_thermal_tx_scheduler;

  localparam int B = 4;
  localparam int G = 3;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_GUARD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       abort = 1'b0;
  logic       heat_en;
  logic       slot_strobe;
  logic [3:0] slot_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_seen = 0;

  int         m_mode = M_IDLE;
  int         m_start = 0;
  int         m_gstart = 0;
  logic [3:0] m_last = 4'd0;
  logic [7:0] m_data = 8'd0;
  logic       m_done = 1'b0;
  int         m_hs = 0;

  thermal_tx_scheduler #(
    .BIT_CYCLES(B),
    .GUARD_CYCLES(G),
    .PREAMBLE(4'b1010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .abort(abort),
    .heat_en(heat_en),
    .slot_strobe(slot_strobe),
    .slot_idx(slot_idx),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic abt, input logic rs);
    tx_valid = valid;
    tx_data  = data;
    abort    = abt;
    rst      = rs;
  endtask

  // Heater value the spec assigns to slot k of a frame carrying byte d.
  function automatic logic slotBit(input int k, input logic [7:0] d);
    logic [3:0] pre;
    pre = 4'b1010;
    if (k < 4) return pre[3 - k];
    if (k < 12) return d[k - 4];
    return ^d;
  endfunction

  // Expected {tx_ready, busy, done, heat_en, slot_strobe, slot_idx} for the current cycle.
  function automatic logic [8:0] modelOutputs();
    int rel;
    int k;
    logic [3:0] k4;
    case (m_mode)
      M_FRAME: begin
        rel = cyc - m_start;
        k   = rel / B;
        k4  = 4'(k);
        return {1'b0, 1'b1, 1'b0, slotBit(k, m_data), (rel % B) == 0, k4};
      end
      M_GUARD: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_last};
      default: return {1'b1, 1'b0, m_done, 1'b0, 1'b0, 4'd0};
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    if (rst) begin
      m_mode = M_IDLE;
      m_done = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_done = 1'b0;
          if (tx_valid) begin
            m_mode  = M_FRAME;
            m_start = cyc;
            m_data  = tx_data;
            m_hs++;
          end
        end
        M_FRAME: begin
          if (abort) begin
            m_mode   = M_GUARD;
            m_gstart = cyc;
            m_last   = 4'((cyc - 1 - m_start) / B);
          end else if (cyc - m_start == 13 * B) begin
            m_mode   = M_GUARD;
            m_gstart = cyc;
            m_last   = 4'd12;
          end
        end
        default: begin
          if (cyc - m_gstart == G) begin
            m_mode = M_IDLE;
            m_done = 1'b1;
          end
        end
      endcase
    end
  endtask

  // One clock: count observed handshakes, step the model, then compare all outputs.
  task automatic stepCycle();
    if (tx_valid && tx_ready && !rst) hs_seen++;
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkOutput("outputs", 32'({tx_ready, busy, done, heat_en, slot_strobe, slot_idx}), 32'(modelOutputs()));
  endtask

  task automatic frame5A();
    logic [12:0] pat;
    logic        pbit;
    pat = 13'b0_0101_1010_0101;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 52; j++) begin
      pbit = pat[j / B];
      checkOutput("h5A_heat", 32'(heat_en), 32'(pbit));
      checkOutput("h5A_strobe", 32'(slot_strobe), 32'((j % B) == 0));
      stepCycle();
    end
    for (int j = 0; j < G; j++) begin
      checkOutput("h5A_guard", 32'({heat_en, busy, done}), 32'(3'b010));
      stepCycle();
    end
    checkOutput("h5A_done", 32'({done, tx_ready}), 32'(2'b11));
    stepCycle();
    checkOutput("h5A_done_pulse", 32'(done), 32'd0);
  endtask

  task automatic frame01();
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 52; j++) begin
      if (j == 4 * B) checkOutput("h01_slot4", 32'({slot_idx, heat_en}), 32'({4'd4, 1'b1}));
      if (j == 12 * B) checkOutput("h01_parity", 32'({slot_idx, heat_en}), 32'({4'd12, 1'b1}));
      stepCycle();
    end
    while (busy && cyc < 100000) stepCycle();
    stepCycle();
  endtask

  task automatic validHeld();
    int hs0;
    hs0 = hs_seen;
    for (int j = 0; j < 56; j++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("held_done", 32'(done), 32'd1);
    checkOutput("held_one_hs", 32'(hs_seen - hs0), 32'd1);
    stepCycle();
  endtask

  task automatic abortSlot4();
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 19; j++) stepCycle();
    checkOutput("abort_slot", 32'(slot_idx), 32'd4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < G; j++) begin
      checkOutput("abort_guard", 32'({heat_en, busy, slot_strobe, done}), 32'(4'b0100));
      stepCycle();
    end
    checkOutput("abort_done", 32'({done, tx_ready}), 32'(2'b11));
    stepCycle();
  endtask

  task automatic resetMidFrame();
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 29; j++) stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_mid", 32'({heat_en, busy, tx_ready, done}), 32'(4'b0010));
    for (int j = 0; j < 6; j++) begin
      stepCycle();
      checkOutput("rst_no_done", 32'(done), 32'd0);
    end
  endtask

  task automatic backToBack();
    int budget;
    applyStimulus(1'b1, 8'h96, 1'b0, 1'b0);
    stepCycle();
    budget = 0;
    while (!done && budget < 200) begin
      applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
      stepCycle();
      budget++;
    end
    if (budget >= 200) begin
      checkOutput("b2b_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("b2b_ready", 32'(tx_ready), 32'd1);
      stepCycle();
      checkOutput("b2b_slot0", 32'({busy, slot_strobe, slot_idx}), 32'({1'b1, 1'b1, 4'd0}));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    while (busy && cyc < 100000) stepCycle();
    stepCycle();
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) stepCycle();
    checkOutput("reset_state", 32'({tx_ready, busy, done, heat_en, slot_strobe, slot_idx}), 32'(9'b1_0000_0000));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ready_after_rst", 32'(tx_ready), 32'd1);

    frame5A();
    frame01();
    validHeld();
    abortSlot4();
    resetMidFrame();
    backToBack();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
      stepCycle();
    end
    checkOutput("hs_count", 32'(hs_seen), 32'(m_hs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
